// File: rtl/clock_set_ctrl.sv
// Time-of-day set controller: runs the seconds/minutes/hours increment chain
// in RUN, and in the set modes turns the up button (single press plus
// auto-repeat) into field adjustments. Returns to RUN after an idle timeout.
module clock_set_ctrl #(
  parameter int unsigned RPT_DLY = 2,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN1HZ,
  input  logic       FASTTICK,
  input  logic       MODEP,
  input  logic       UPLVL,
  input  logic       SEC_MAX,
  input  logic       MIN_MAX,
  output logic       SECINC,
  output logic       MININC,
  output logic       HOURINC,
  output logic       SECCLR,
  output logic       MINCLR,
  output logic       HOURCLR,
  output logic [1:0] MODE,
  output logic       BLINK
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [3:0] RPT_LIM = 4'(RPT_DLY);
  localparam logic [6:0] TO_LIM  = 7'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [5:0] idle_q, idle_d;
  logic       upl_q, upl_d;
  logic       blink_q, blink_d;
  logic       secinc_q, secinc_d;
  logic       mininc_q, mininc_d;
  logic       hourinc_q, hourinc_d;
  logic       secclr_q, secclr_d;

  logic       up_rise;
  logic       up_rpt;
  logic       up_ev;
  logic       in_set;
  logic       timeout;
  logic       changing;

  // Next-state, counters and registered output values.
  always_comb begin
    up_rise  = UPLVL & ~upl_q;
    // Repeat uses the pre-increment hold count, so the first repeat lands on
    // the tick after the count reaches the limit.
    up_rpt   = FASTTICK & UPLVL & ~up_rise & (hold_q >= RPT_LIM);
    up_ev    = up_rise | up_rpt;
    in_set   = (state_q != RUN);
    timeout  = in_set & EN1HZ & (({1'b0, idle_q} + 7'd1) >= TO_LIM);

    state_d = state_q;
    if (MODEP) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end else if (timeout) begin
      state_d = RUN;
    end
    changing = (state_d != state_q);

    upl_d = UPLVL;

    hold_d = hold_q;
    if (changing || up_rise) begin
      hold_d = '0;
    end else if (FASTTICK && UPLVL && (hold_q < RPT_LIM)) begin
      hold_d = hold_q + 4'd1;
    end

    idle_d = idle_q;
    if (up_ev || MODEP || changing || (state_d == RUN)) begin
      idle_d = '0;
    end else if (EN1HZ) begin
      idle_d = idle_q + 6'd1;
    end

    blink_d = blink_q;
    if (changing || (state_d == RUN) || UPLVL) begin
      blink_d = 1'b1;
    end else if (FASTTICK) begin
      blink_d = ~blink_q;
    end

    // Actions always follow the state sampled on this edge, even when the
    // state advances at the same time.
    secclr_d  = (state_q == SET_SEC) & up_ev;
    secinc_d  = (state_q == RUN) & EN1HZ & ~secclr_d;
    mininc_d  = ((state_q == RUN) & EN1HZ & SEC_MAX) |
                ((state_q == SET_MIN) & up_ev);
    hourinc_d = ((state_q == RUN) & EN1HZ & SEC_MAX & MIN_MAX) |
                ((state_q == SET_HOUR) & up_ev);
  end

  // State and output registers; reset holds the counters cleared and strobes
  // the clear outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      hold_q    <= '0;
      idle_q    <= '0;
      upl_q     <= 1'b0;
      blink_q   <= 1'b1;
      secinc_q  <= 1'b0;
      mininc_q  <= 1'b0;
      hourinc_q <= 1'b0;
      secclr_q  <= 1'b1;
      MINCLR    <= 1'b1;
      HOURCLR   <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      idle_q    <= idle_d;
      upl_q     <= upl_d;
      blink_q   <= blink_d;
      secinc_q  <= secinc_d;
      mininc_q  <= mininc_d;
      hourinc_q <= hourinc_d;
      secclr_q  <= secclr_d;
      MINCLR    <= 1'b0;
      HOURCLR   <= 1'b0;
    end
  end

  // Output mapping.
  always_comb begin
    MODE    = state_q;
    BLINK   = blink_q;
    SECINC  = secinc_q;
    MININC  = mininc_q;
    HOURINC = hourinc_q;
    SECCLR  = secclr_q;
  end

endmodule
